// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM state
// encodings and a frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Bits on the wire per frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO holding received frames with their error tags.
module uart_fifo #(
  parameter int Width     = 10,
  parameter int DepthLog2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [Width-1:0]     wdata,
  input  logic                 pop,
  output logic [Width-1:0]     rdata,
  output logic [DepthLog2:0]   level,
  output logic                 full,
  output logic                 empty
);

  localparam logic [DepthLog2:0] DEPTH = {1'b1, {DepthLog2{1'b0}}};

  logic [Width-1:0]     mem [2**DepthLog2];
  logic [DepthLog2-1:0] wr_ptr;
  logic [DepthLog2-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH);
  assign do_pop  = pop && !empty;
  // A pop in the same clk frees the slot, so a push into a full FIFO is then legal.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART with runtime baud divisor, selectable framing and a
// buffered RX path tagging each byte with parity/frame error flags.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int DataBits = 8,
  parameter int Parity   = 0,
  parameter int StopBits = 1,
  parameter int DivWidth = 16,
  parameter int OsLog2   = 4,
  parameter int FifoLog2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DivWidth-1:0] div,
  input  logic                rin,
  output logic                rout,
  input  logic [DataBits-1:0] din,
  input  logic                send,
  output logic                txbusy,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_perr,
  output logic                rx_ferr,
  output logic                rx_valid,
  input  logic                rx_pop,
  output logic [FifoLog2:0]   rx_level,
  output logic                rx_overrun,
  input  logic                clr_err
);

  localparam int FrameBits = frame_bits(DataBits, Parity, StopBits);
  localparam int BitW      = $clog2(FrameBits);
  localparam logic [BitW-1:0]   LAST_DATA = BitW'(DataBits);
  localparam logic [BitW-1:0]   LAST_BIT  = BitW'(FrameBits - 1);
  localparam logic [OsLog2-1:0] PH_LAST   = '1;
  localparam logic [OsLog2-1:0] PH_HALF   = OsLog2'((1 << (OsLog2 - 1)) - 1);
  localparam logic              HAS_PAR   = (Parity != PAR_NONE);
  localparam logic              ODD_PAR   = (Parity == PAR_ODD);

  logic [DivWidth-1:0] tick_cnt;
  logic [DivWidth-1:0] div_q;
  logic                tick;

  assign tick = (tick_cnt == div_q);

  // The divisor is captured only at the wrap so a change never truncates a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= div;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  tx_state_t           tx_state;
  logic [OsLog2-1:0]   tx_phase;
  logic [BitW-1:0]     tx_bit;
  logic [DataBits-1:0] tx_shift;
  logic                tx_par;

  // tx_bit indexes the frame position currently on the line (0 = start bit).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      rout     <= 1'b1;
      txbusy   <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (send) begin
        tx_state <= TX_START;
        tx_phase <= '0;
        tx_bit   <= '0;
        tx_shift <= din;
        tx_par   <= ^din ^ ODD_PAR;
        rout     <= 1'b0;
        txbusy   <= 1'b1;
      end
    end else if (tick) begin
      tx_phase <= tx_phase + 1'b1;
      if (tx_phase == PH_LAST) begin
        tx_bit <= tx_bit + 1'b1;
        if (tx_bit == LAST_BIT) begin
          tx_state <= TX_IDLE;
          rout     <= 1'b1;
          txbusy   <= 1'b0;
        end else if (tx_bit < LAST_DATA) begin
          tx_state <= TX_DATA;
          rout     <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
        end else if (tx_bit == LAST_DATA && HAS_PAR) begin
          tx_state <= TX_PAR;
          rout     <= tx_par;
        end else begin
          tx_state <= TX_STOP;
          rout     <= 1'b1;
        end
      end
    end
  end

  logic       rin_s1;
  logic       rin_s2;
  logic [2:0] rx_samp;
  logic       rx_filt;

  assign rx_filt = (rx_samp[0] & rx_samp[1]) | (rx_samp[0] & rx_samp[2]) | (rx_samp[1] & rx_samp[2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rin_s1  <= 1'b1;
      rin_s2  <= 1'b1;
      rx_samp <= 3'b111;
    end else begin
      rin_s1 <= rin;
      rin_s2 <= rin_s1;
      if (tick) rx_samp <= {rx_samp[1:0], rin_s2};
    end
  end

  rx_state_t           rx_state;
  logic [OsLog2-1:0]   rx_phase;
  logic [BitW-1:0]     rx_bit;
  logic [DataBits-1:0] rx_shift;
  logic                rx_perr_q;
  logic                rx_ferr_q;
  logic                rx_ferr_now;
  logic                rx_push;
  logic [DataBits+1:0] rx_wdata;

  assign rx_ferr_now = rx_ferr_q | ~rx_filt;

  // After the start-bit centre check, every later sample lands on a bit centre.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      rx_phase  <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_perr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_push   <= 1'b0;
      rx_wdata  <= '0;
    end else begin
      rx_push <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rx_filt) begin
              rx_state <= RX_START;
              rx_phase <= '0;
            end
          end
          RX_START: begin
            if (rx_phase == PH_HALF) begin
              if (rx_filt) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_state  <= RX_DATA;
                rx_phase  <= '0;
                rx_bit    <= BitW'(1);
                rx_perr_q <= 1'b0;
                rx_ferr_q <= 1'b0;
              end
            end else begin
              rx_phase <= rx_phase + 1'b1;
            end
          end
          RX_WAIT_HIGH: begin
            if (rx_filt) rx_state <= RX_IDLE;
          end
          default: begin
            rx_phase <= rx_phase + 1'b1;
            if (rx_phase == PH_LAST) begin
              rx_bit <= rx_bit + 1'b1;
              if (rx_state == RX_DATA) begin
                rx_shift <= {rx_filt, rx_shift[DataBits-1:1]};
                if (rx_bit == LAST_DATA) begin
                  if (HAS_PAR) rx_state <= RX_PAR;
                  else         rx_state <= RX_STOP;
                end
              end else if (rx_state == RX_PAR) begin
                rx_perr_q <= ^rx_shift ^ rx_filt ^ ODD_PAR;
                rx_state  <= RX_STOP;
              end else if (rx_bit == LAST_BIT) begin
                rx_push  <= 1'b1;
                rx_wdata <= {rx_perr_q, rx_ferr_now, rx_shift};
                if (rx_ferr_now) rx_state <= RX_WAIT_HIGH;
                else             rx_state <= RX_IDLE;
              end else begin
                rx_ferr_q <= rx_ferr_now;
              end
            end
          end
        endcase
      end
    end
  end

  logic [DataBits+1:0] fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;

  uart_fifo #(
    .Width     (DataBits + 2),
    .DepthLog2 (FifoLog2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_wdata),
    .pop   (rx_pop),
    .rdata (fifo_rdata),
    .level (rx_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_data  = fifo_rdata[DataBits-1:0];
  assign rx_ferr  = fifo_rdata[DataBits];
  assign rx_perr  = fifo_rdata[DataBits+1];
  assign rx_valid = !fifo_empty;

  // Setting has priority over clearing so a drop coinciding with clr_err is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 rx_overrun <= 1'b0;
    else if (rx_push && fifo_full && !rx_pop)  rx_overrun <= 1'b1;
    else if (clr_err)                          rx_overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: TX waveforms in three framings, loopback,
// frame errors, FIFO overflow, glitch rejection and mid-frame reset.
module tb_uart_cfg;

  logic        clk;
  logic        reset;
  logic [15:0] div;
  logic        rin_drv;
  logic        loopback;
  logic        rin_main;
  logic [7:0]  din_main;
  logic        send_main;
  logic [7:0]  din_aux;
  logic        send_aux;
  logic        rx_pop;
  logic        clr_err;

  logic        rout, txbusy, rx_perr, rx_ferr, rx_valid, rx_overrun;
  logic [7:0]  rx_data;
  logic [4:0]  rx_level;

  logic        e_rout, e_busy, e_perr, e_ferr, e_valid, e_ovr;
  logic [7:0]  e_data;
  logic [4:0]  e_level;
  logic        o_rout, o_busy, o_perr, o_ferr, o_valid, o_ovr;
  logic [7:0]  o_data;
  logic [4:0]  o_level;

  int checks;
  int fails;

  assign rin_main = loopback ? rout : rin_drv;

  uart_cfg #(.DataBits(8), .Parity(0), .StopBits(1), .DivWidth(16), .OsLog2(4), .FifoLog2(4)) dut (
    .clk(clk), .reset(reset), .div(div), .rin(rin_main), .rout(rout), .din(din_main), .send(send_main),
    .txbusy(txbusy), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .rx_level(rx_level), .rx_overrun(rx_overrun), .clr_err(clr_err)
  );

  uart_cfg #(.DataBits(8), .Parity(2), .StopBits(1), .DivWidth(16), .OsLog2(4), .FifoLog2(4)) dut_even (
    .clk(clk), .reset(reset), .div(div), .rin(1'b1), .rout(e_rout), .din(din_aux), .send(send_aux),
    .txbusy(e_busy), .rx_data(e_data), .rx_perr(e_perr), .rx_ferr(e_ferr), .rx_valid(e_valid),
    .rx_pop(1'b0), .rx_level(e_level), .rx_overrun(e_ovr), .clr_err(1'b0)
  );

  uart_cfg #(.DataBits(8), .Parity(1), .StopBits(2), .DivWidth(16), .OsLog2(4), .FifoLog2(4)) dut_odd (
    .clk(clk), .reset(reset), .div(div), .rin(1'b1), .rout(o_rout), .din(din_aux), .send(send_aux),
    .txbusy(o_busy), .rx_data(o_data), .rx_perr(o_perr), .rx_ferr(o_ferr), .rx_valid(o_valid),
    .rx_pop(1'b0), .rx_level(o_level), .rx_overrun(o_ovr), .clr_err(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected line pattern, LSB = first bit on the wire; unused upper bits idle high.
  function automatic logic [15:0] build_frame(input logic [7:0] d, input int par);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    if (par == 2) f[9] = ^d;
    if (par == 1) f[9] = ~^d;
    return f;
  endfunction

  function automatic logic exp_line(input logic [15:0] f, input int nbits, input int i);
    if (i < nbits * 16) return f[i/16];
    return 1'b1;
  endfunction

  task automatic tick_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    for (int n = 0; n < limit && !rx_valid; n++) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input int limit);
    for (int n = 0; n < limit && txbusy; n++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    din_main  = d;
    send_main = 1'b1;
    @(negedge clk);
    send_main = 1'b0;
  endtask

  // Drives one 8N1 frame on rin_drv; optionally pops exactly when the RX pushes.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_val, input int bit_clks, input logic pop_on_push);
    rin_drv = 1'b0;
    tick_clks(bit_clks);
    for (int k = 0; k < 8; k++) begin
      rin_drv = d[k];
      tick_clks(bit_clks);
    end
    rin_drv = stop_val;
    for (int j = 0; j < bit_clks; j++) begin
      rx_pop = pop_on_push & dut.rx_push;
      @(negedge clk);
    end
    rx_pop = 1'b0;
  endtask

  initial begin
    logic [15:0] fm, fe, fo;
    int busy_m, busy_e, busy_o, errs_m, errs_e, errs_o;
    logic par_e, par_o;

    checks = 0; fails = 0;
    reset = 1'b1; div = 16'd0; rin_drv = 1'b1; loopback = 1'b0;
    din_main = 8'h00; send_main = 1'b0; din_aux = 8'h00; send_aux = 1'b0;
    rx_pop = 1'b0; clr_err = 1'b0;

    tick_clks(3);
    checkOutput("rst_rout", rout, 1'b1);
    checkOutput("rst_txbusy", txbusy, 1'b0);
    checkOutput("rst_valid", rx_valid, 1'b0);
    checkOutput("rst_level", rx_level, 5'd0);
    checkOutput("rst_overrun", rx_overrun, 1'b0);
    checkOutput("rst_data", {rx_perr, rx_ferr, rx_data}, 10'd0);
    reset = 1'b0;
    tick_clks(5);

    // TX waveforms at div=0 (one tick per clk, 16 clks per bit)
    fm = build_frame(8'hA5, 0);
    fe = build_frame(8'h03, 2);
    fo = build_frame(8'h03, 1);
    busy_m = 0; busy_e = 0; busy_o = 0; errs_m = 0; errs_e = 0; errs_o = 0;
    par_e = 1'bx; par_o = 1'bx;
    din_main = 8'hA5; din_aux = 8'h03;
    send_main = 1'b1; send_aux = 1'b1;
    @(negedge clk);
    send_main = 1'b0; send_aux = 1'b0;
    for (int i = 0; i < 220; i++) begin
      if (txbusy) busy_m++;
      if (e_busy) busy_e++;
      if (o_busy) busy_o++;
      if (rout !== exp_line(fm, 10, i)) errs_m++;
      if (e_rout !== exp_line(fe, 11, i)) errs_e++;
      if (o_rout !== exp_line(fo, 12, i)) errs_o++;
      if (i == 9 * 16 + 8) begin
        par_e = e_rout;
        par_o = o_rout;
      end
      send_main = (i >= 20 && i < 100);
      din_main  = (i >= 20) ? 8'hFF : 8'hA5;
      @(negedge clk);
    end
    send_main = 1'b0;
    checkOutput("a5_busy_clks", busy_m, 160);
    checkOutput("a5_wave_errs", errs_m, 0);
    checkOutput("even_busy_clks", busy_e, 176);
    checkOutput("even_wave_errs", errs_e, 0);
    checkOutput("even_par_bit", par_e, 1'b0);
    checkOutput("odd2_busy_clks", busy_o, 192);
    checkOutput("odd2_wave_errs", errs_o, 0);
    checkOutput("odd2_par_bit", par_o, 1'b1);

    // Loopback at div=3
    div = 16'd3;
    tick_clks(10);
    loopback = 1'b1;
    tick_clks(5);
    send_byte(8'h5A);
    wait_valid(3000);
    checkOutput("lb_valid", rx_valid, 1'b1);
    checkOutput("lb_data", rx_data, 8'h5A);
    checkOutput("lb_perr", rx_perr, 1'b0);
    checkOutput("lb_ferr", rx_ferr, 1'b0);
    checkOutput("lb_level", rx_level, 5'd1);
    wait_tx_idle(1000);
    pop_one();
    checkOutput("lb_pop_valid", rx_valid, 1'b0);

    // Bad stop bit followed by a long break
    loopback = 1'b0;
    rin_drv = 1'b1;
    tick_clks(20);
    applyStimulus(8'h33, 1'b0, 64, 1'b0);
    rin_drv = 1'b0;
    tick_clks(3 * 640);
    checkOutput("brk_level", rx_level, 5'd1);
    checkOutput("brk_ferr", rx_ferr, 1'b1);
    checkOutput("brk_perr", rx_perr, 1'b0);
    checkOutput("brk_data", rx_data, 8'h33);
    rin_drv = 1'b1;
    tick_clks(200);
    applyStimulus(8'h11, 1'b1, 64, 1'b0);
    rin_drv = 1'b1;
    tick_clks(100);
    checkOutput("brk_level2", rx_level, 5'd2);
    pop_one();
    checkOutput("brk_second_data", rx_data, 8'h11);
    checkOutput("brk_second_ferr", rx_ferr, 1'b0);
    pop_one();
    checkOutput("brk_empty", rx_valid, 1'b0);

    // Overflow: 17 frames into a 16-deep FIFO at div=0
    div = 16'd0;
    tick_clks(10);
    for (int i = 0; i < 17; i++) applyStimulus(8'(8'h20 + i), 1'b1, 16, 1'b0);
    rin_drv = 1'b1;
    tick_clks(50);
    checkOutput("ovf_level", rx_level, 5'd16);
    checkOutput("ovf_flag", rx_overrun, 1'b1);
    checkOutput("ovf_head", rx_data, 8'h20);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checkOutput("ovf_cleared", rx_overrun, 1'b0);
    applyStimulus(8'h40, 1'b1, 16, 1'b1);
    rin_drv = 1'b1;
    tick_clks(50);
    checkOutput("full_pushpop_level", rx_level, 5'd16);
    checkOutput("full_pushpop_ovr", rx_overrun, 1'b0);
    for (int i = 0; i < 15; i++) begin
      checkOutput("drain_data", rx_data, 8'(8'h21 + i));
      pop_one();
    end
    checkOutput("drain_last", rx_data, 8'h40);
    pop_one();
    checkOutput("drain_empty", rx_valid, 1'b0);

    // Short low glitch is rejected as a false start
    rin_drv = 1'b0;
    tick_clks(4);
    rin_drv = 1'b1;
    tick_clks(100);
    checkOutput("glitch_level", rx_level, 5'd0);

    // Reset in the middle of a loopback frame with one entry already buffered
    div = 16'd3;
    tick_clks(10);
    loopback = 1'b1;
    send_byte(8'hC3);
    wait_valid(3000);
    checkOutput("pre_rst_data", rx_data, 8'hC3);
    wait_tx_idle(1000);
    tick_clks(5);
    send_byte(8'h99);
    tick_clks(300);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_rout", rout, 1'b1);
    checkOutput("mid_rst_txbusy", txbusy, 1'b0);
    checkOutput("mid_rst_level", rx_level, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    tick_clks(10);
    send_byte(8'h7E);
    wait_valid(3000);
    checkOutput("post_rst_data", rx_data, 8'h7E);
    checkOutput("post_rst_err", {rx_perr, rx_ferr}, 2'b00);
    checkOutput("post_rst_level", rx_level, 5'd1);
    wait_tx_idle(1000);
    checkOutput("post_rst_idle", {txbusy, rout}, 2'b01);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
Parametrised second-generation UART with a runtime baud divisor and configurable data bits, parity and stop bits. Adds a buffered RX path with per-byte error tagging and overrun detection. Sits between the core logic and the RS232 pins, replacing the fixed-format 8N1 UART wherever software-selectable baud or framing is needed.

Parameters:
DataBits, 8, data bits per frame; legal range 5..9.
Parity, 0, parity mode: 0 = none, 1 = odd, 2 = even.
StopBits, 1, stop bits per frame; legal values 1 or 2.
DivWidth, 16, width of the runtime baud divisor.
OsLog2, 4, oversample exponent; one bit time is 2**OsLog2 sample ticks.
FifoLog2, 4, RX FIFO depth exponent; depth is 2**FifoLog2.

Ports:
clk  in  1  reference clock; all logic is single-clock.
reset  in  1  asynchronous, active-high reset.
div  in  DivWidth  sample tick asserts once every div+1 clk cycles.
rin  in  1  RS232 receive line (asynchronous).
rout  out  1  RS232 transmit line.
din  in  DataBits  TX data; din[0] is sent first.
send  in  1  TX request.
txbusy  out  1  TX frame in progress.
rx_data  out  DataBits  FIFO head data.
rx_perr  out  1  parity error flag for the FIFO head.
rx_ferr  out  1  frame error flag for the FIFO head.
rx_valid  out  1  FIFO not empty.
rx_pop  in  1  consume the FIFO head.
rx_level  out  FifoLog2+1  FIFO occupancy, 0..depth.
rx_overrun  out  1  sticky; a frame was dropped because the FIFO was full.
clr_err  in  1  clears rx_overrun.

Behaviour:
- Reset (asynchronous): rout=1, txbusy=0, rx_valid=0, rx_level=0, rx_overrun=0, rx_data/rx_perr/rx_ferr=0. Any frame in progress is aborted and the FIFO is emptied.
- Tick generator: counter runs 0..div; the tick pulse lasts one clk when counter==div, then the counter returns to 0. div=0 gives a tick every clk. A new div value takes effect at the next wrap.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - In IDLE, send=1 latches din and sets txbusy on the next clk. The TX tick-phase counter clears on that latch.
  - Every bit lasts exactly 2**OsLog2 ticks. Order: start(0), data LSB first, parity if enabled, StopBits×1.
  - Parity bit: even mode makes the total count of 1s in data+parity even; odd mode makes it odd.
  - txbusy deasserts in the clk after the last stop bit completes. A send in that same clk is accepted.
  - send while busy is ignored; no queueing.
- RX path: rin passes a 2-FF synchroniser, then a 3-sample majority filter on ticks.
- RX FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: a filtered 0 on a tick moves to START.
  - START: after 2**(OsLog2-1) ticks, resample. If the sample is 1 (false start), return to IDLE with no FIFO entry.
  - Subsequent samples are taken every 2**OsLog2 ticks, at bit centre.
  - perr is set on parity mismatch; it is always 0 when Parity=0.
  - ferr is set if any stop sample is 0.
  - At the final stop sample, push {perr, ferr, data} to the FIFO.
  - After the push, go to IDLE if ferr=0, otherwise go to WAIT_HIGH. WAIT_HIGH holds until a filtered 1 is seen (break handling).
- FIFO (sub-module, first-word fall-through): rx_data/rx_perr/rx_ferr reflect the head whenever rx_valid=1.
  - rx_pop with rx_valid=1 removes the head in one clk. rx_pop while empty is ignored.
  - Push while full and no pop: the new frame is dropped, contents are unchanged, and rx_overrun=1.
  - Push and pop in the same clk while full: both are performed, no overrun, and rx_level is unchanged.
  - Pointers wrap modulo depth. rx_level is the true count, up to depth.
  - rx_overrun clears on clr_err. If an overrun and clr_err occur in the same clk, the overrun wins (the flag stays 1).
- Latency: rx_valid rises 2 clks after the final stop sample tick.

Decomposition:
- Shared package uart_pkg holds:
  - the parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the TX and RX state encodings;
  - a function computing frame length in bits from DataBits, Parity and StopBits.
- One sub-module, uart_fifo: parametrised width and depth, FWFT, providing level and full/empty outputs.
- Tick generator, TX FSM and RX FSM stay inline.

Test Plan:
- 8N1, div=0, OsLog2=4, send 0xA5 -> rout is 0 for 16 clks, then bits 1,0,1,0,0,1,0,1 for 16 clks each, then 1. txbusy is high for exactly 160 clks.
- Parity=2 send 0x03 -> parity bit 0. Parity=1 send 0x03 -> parity bit 1. Parity=1 with StopBits=2 -> txbusy high for 12×16 clks.
- Loopback rout->rin with div=3: send 0x5A -> rx_valid=1, rx_data=0x5A, rx_perr=0, rx_ferr=0, rx_level=1. rx_pop -> rx_valid=0.
- Drive a frame with its stop bit at 0, then hold rin low for 3 frame times -> exactly one entry with ferr=1 and no further entries. rin high plus a valid 0x11 frame -> second entry 0x11.
- FifoLog2=4: 17 frames with no pop -> rx_level=16, rx_overrun=1, entries equal the first 16 bytes. clr_err -> rx_overrun=0. Full FIFO with a push and pop in the same clk -> rx_level stays 16, no overrun.
- rin low glitch of 4 ticks -> no entry. Assert reset mid-TX and mid-RX -> rout=1 immediately, txbusy=0, rx_level=0. After release, a send of 0x7E completes normally.
